octave_controller: RTL and testbench

- Sequences the synthesizer's octave-select register from the front-panel up/down buttons.
- Converts button levels into single step events, with auto-repeat while a button is held.
- Defers every octave change until no note is sounding, so a note never changes pitch mid-note.
- Drives oct_sel to the oscillator/divider datapath and gives a one-cycle strobe on each change.

---
 rtl/octave_controller.sv | 140 ++++++++++++++
 tb/tb_octave_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octave_controller.sv
// Octave-select sequencer: turns up/down button levels into single-step requests
// (with auto-repeat) and applies them only while no note is sounding.
module octave_controller #(
    parameter int OCT_W         = 2,
    parameter int NUM_OCT       = 4,
    parameter int DEFAULT_OCT   = 0,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             oct_up,
    input  logic             oct_down,
    input  logic             note_busy,
    output logic [OCT_W-1:0] oct_sel,
    output logic             oct_strobe,
    output logic             oct_pending
);

    localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PEND_UP = 2'd1;
    localparam logic [1:0] S_PEND_DN = 2'd2;

    localparam logic [OCT_W-1:0] LP_MAX      = OCT_W'(NUM_OCT - 1);
    localparam logic [OCT_W-1:0] LP_DEF      = OCT_W'(DEFAULT_OCT);
    localparam logic [OCT_W:0]   LP_NUM      = (OCT_W + 1)'(NUM_OCT);
    localparam logic [CNT_W-1:0] LP_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]       w_btn;
    logic [1:0]       w_edge;
    logic [1:0]       r_prev;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             w_one_held;
    logic             w_rep_clr;
    logic             w_rep_fire;
    logic             w_up_evt;
    logic             w_dn_evt;
    logic [1:0]       w_evt_state;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [OCT_W-1:0] r_oct_sel;
    logic [OCT_W-1:0] w_sel_next;
    logic             r_strobe;
    logic             w_strobe_next;
    logic             w_sel_illegal;

    assign w_btn = {oct_down, oct_up};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            assign w_edge[gi] = w_btn[gi] & ~r_prev[gi];
        end
    endgenerate

    // History resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 2'b11;
        end else begin
            r_prev <= w_btn;
        end
    end

    assign w_one_held = oct_up ^ oct_down;
    assign w_rep_clr  = ~w_one_held | (|w_edge);
    assign w_rep_fire = ~w_rep_clr & (r_rep_cnt == LP_REP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (w_rep_clr || w_rep_fire) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
        end
    end

    // Simultaneous press edges cancel each other; repeats only exist with one button held.
    assign w_up_evt = (w_edge[0] & ~w_edge[1]) | (w_rep_fire & oct_up);
    assign w_dn_evt = (w_edge[1] & ~w_edge[0]) | (w_rep_fire & oct_down);

    assign w_evt_state   = w_up_evt ? S_PEND_UP : (w_dn_evt ? S_PEND_DN : S_IDLE);
    assign w_sel_illegal = ({1'b0, r_oct_sel} >= LP_NUM);

    // When a step is applied, an event arriving in the same cycle becomes the next request.
    always_comb begin
        w_state_next  = r_state;
        w_sel_next    = r_oct_sel;
        w_strobe_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = w_evt_state;
            end
            S_PEND_UP, S_PEND_DN: begin
                if (!note_busy) begin
                    w_state_next = w_evt_state;
                    if (w_sel_illegal) begin
                        w_sel_next    = LP_MAX;
                        w_strobe_next = 1'b1;
                    end else if (r_state == S_PEND_UP) begin
                        if (r_oct_sel != LP_MAX) begin
                            w_sel_next    = r_oct_sel + OCT_W'(1);
                            w_strobe_next = 1'b1;
                        end
                    end else begin
                        if (r_oct_sel != '0) begin
                            w_sel_next    = r_oct_sel - OCT_W'(1);
                            w_strobe_next = 1'b1;
                        end
                    end
                end else if ((r_state == S_PEND_UP && w_dn_evt) ||
                             (r_state == S_PEND_DN && w_up_evt)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_oct_sel <= LP_DEF;
            r_strobe  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_oct_sel <= w_sel_next;
            r_strobe  <= w_strobe_next;
        end
    end

    assign oct_sel     = r_oct_sel;
    assign oct_strobe  = r_strobe;
    assign oct_pending = (r_state != S_IDLE);

endmodule

// File: tb/tb_octave_controller.sv
// Bench for octave_controller: directed scenarios plus randomized traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_octave_controller;

    localparam int OCT_W   = 2;
    localparam int NUM_OCT = 4;
    localparam int DEF_OCT = 0;
    localparam int REP     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             oct_up;
    logic             oct_down;
    logic             note_busy;
    logic [OCT_W-1:0] oct_sel;
    logic             oct_strobe;
    logic             oct_pending;

    int checks   = 0;
    int failures = 0;

    // Reference model: octave as an integer, queued request as -1/0/+1,
    // and the number of cycles a single button has been held steadily.
    int m_oct;
    int m_pend;
    int m_hold;
    bit m_up_prev;
    bit m_dn_prev;
    bit m_strobe;

    octave_controller #(
        .OCT_W        (OCT_W),
        .NUM_OCT      (NUM_OCT),
        .DEFAULT_OCT  (DEF_OCT),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .oct_up     (oct_up),
        .oct_down   (oct_down),
        .note_busy  (note_busy),
        .oct_sel    (oct_sel),
        .oct_strobe (oct_strobe),
        .oct_pending(oct_pending)
    );

    always #5 clk = ~clk;

    // Advance one clock: update the model from the current inputs, then sample 1ns after the edge.
    task automatic step();
        bit eu;
        bit ed;
        bit rep;
        int evt;
        int tgt;
        if (rst) begin
            m_oct     = DEF_OCT;
            m_pend    = 0;
            m_hold    = 0;
            m_up_prev = 1'b1;
            m_dn_prev = 1'b1;
            m_strobe  = 1'b0;
        end else begin
            eu = oct_up && !m_up_prev;
            ed = oct_down && !m_dn_prev;
            if ((oct_up != oct_down) && !eu && !ed) m_hold++;
            else m_hold = 0;
            rep = (m_hold > 0) && (m_hold % REP == 0);
            evt = 0;
            if (eu && !ed) evt = 1;
            else if (ed && !eu) evt = -1;
            else if (rep) evt = oct_up ? 1 : -1;
            m_strobe = 1'b0;
            if (m_pend == 0) begin
                m_pend = evt;
            end else if (!note_busy) begin
                tgt = m_oct + m_pend;
                if (tgt >= 0 && tgt < NUM_OCT) begin
                    m_oct    = tgt;
                    m_strobe = 1'b1;
                end
                m_pend = evt;
            end else if (evt == -m_pend) begin
                m_pend = 0;
            end
            m_up_prev = oct_up;
            m_dn_prev = oct_down;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        oct_up    = 1'b0;
        oct_down  = 1'b0;
        note_busy = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic tap(input bit up);
        if (up) oct_up = 1'b1;
        else oct_down = 1'b1;
        step();
        oct_up   = 1'b0;
        oct_down = 1'b0;
        step();
    endtask

    task automatic test_reset();
        oct_up    = 1'b0;
        oct_down  = 1'b0;
        note_busy = 1'b0;
        rst       = 1'b1;
        step();
        step();
        checks++;
        if (oct_sel !== 2'(DEF_OCT) || oct_strobe !== 1'b0 || oct_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: sel=%0d strobe=%b pending=%b, expected sel=%0d strobe=0 pending=0",
                     oct_sel, oct_strobe, oct_pending, DEF_OCT);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_up();
        do_reset();
        oct_up = 1'b1;
        step();
        checks++;
        if (oct_pending !== 1'b1 || oct_sel !== 2'd0 || oct_strobe !== 1'b0) begin
            failures++;
            $display("FAIL single_up_n1: pending=%b sel=%0d strobe=%b, expected pending=1 sel=0 strobe=0",
                     oct_pending, oct_sel, oct_strobe);
        end
        step();
        checks++;
        if (oct_sel !== 2'd1 || oct_strobe !== 1'b1 || oct_pending !== 1'b0) begin
            failures++;
            $display("FAIL single_up_n2: sel=%0d strobe=%b pending=%b, expected sel=1 strobe=1 pending=0",
                     oct_sel, oct_strobe, oct_pending);
        end
        oct_up = 1'b0;
        step();
        checks++;
        if (oct_sel !== 2'd1 || oct_strobe !== 1'b0) begin
            failures++;
            $display("FAIL single_up_n3: sel=%0d strobe=%b, expected sel=1 strobe=0", oct_sel, oct_strobe);
        end
    endtask

    task automatic test_saturate();
        int exp;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tap(1'b1);
            exp = (i < NUM_OCT) ? i : NUM_OCT - 1;
            checks++;
            if (oct_sel !== exp[1:0] || oct_strobe !== (i < NUM_OCT) || oct_pending !== 1'b0) begin
                failures++;
                $display("FAIL saturate_up_%0d: sel=%0d strobe=%b pending=%b, expected sel=%0d strobe=%b pending=0",
                         i, oct_sel, oct_strobe, oct_pending, exp, (i < NUM_OCT));
            end
        end
        for (int i = 1; i <= 4; i++) begin
            tap(1'b0);
            exp = (NUM_OCT - 1 - i > 0) ? NUM_OCT - 1 - i : 0;
            checks++;
            if (oct_sel !== exp[1:0] || oct_strobe !== (i < NUM_OCT) || oct_pending !== 1'b0) begin
                failures++;
                $display("FAIL saturate_dn_%0d: sel=%0d strobe=%b pending=%b, expected sel=%0d strobe=%b pending=0",
                         i, oct_sel, oct_strobe, oct_pending, exp, (i < NUM_OCT));
            end
        end
    endtask

    task automatic test_busy_hold();
        int bad;
        do_reset();
        tap(1'b1);
        tap(1'b1);
        note_busy = 1'b1;
        oct_down  = 1'b1;
        step();
        oct_down = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (oct_pending !== 1'b1 || oct_sel !== 2'd2 || oct_strobe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_hold: %0d of 50 cycles not holding, last sel=%0d pending=%b, expected sel=2 pending=1",
                     bad, oct_sel, oct_pending);
        end
        note_busy = 1'b0;
        step();
        checks++;
        if (oct_sel !== 2'd1 || oct_strobe !== 1'b1 || oct_pending !== 1'b0) begin
            failures++;
            $display("FAIL busy_release: sel=%0d strobe=%b pending=%b, expected sel=1 strobe=1 pending=0",
                     oct_sel, oct_strobe, oct_pending);
        end
    endtask

    task automatic test_cancel();
        int bad;
        do_reset();
        tap(1'b1);
        note_busy = 1'b1;
        tap(1'b1);
        checks++;
        if (oct_pending !== 1'b1) begin
            failures++;
            $display("FAIL cancel_queued: pending=%b, expected 1", oct_pending);
        end
        oct_down = 1'b1;
        step();
        checks++;
        if (oct_pending !== 1'b0) begin
            failures++;
            $display("FAIL cancel_opposite: pending=%b, expected 0", oct_pending);
        end
        oct_down  = 1'b0;
        note_busy = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (oct_strobe !== 1'b0 || oct_pending !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || oct_sel !== 2'd1) begin
            failures++;
            $display("FAIL cancel_after: sel=%0d bad_cycles=%0d, expected sel=1 bad_cycles=0", oct_sel, bad);
        end
        oct_up   = 1'b1;
        oct_down = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (oct_pending !== 1'b0 || oct_strobe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || oct_sel !== 2'd1) begin
            failures++;
            $display("FAIL both_buttons: sel=%0d bad_cycles=%0d, expected sel=1 bad_cycles=0", oct_sel, bad);
        end
        oct_up   = 1'b0;
        oct_down = 1'b0;
        step();
    endtask

    task automatic test_repeat();
        int strobes[$];
        int exp_k[3] = '{2, 10, 18};
        int cnt;
        do_reset();
        oct_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (oct_strobe === 1'b1) strobes.push_back(k);
        end
        checks++;
        if (strobes.size() != 3) begin
            failures++;
            $display("FAIL repeat_count: strobes=%0d, expected 3", strobes.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= strobes.size() || strobes[i] != exp_k[i]) begin
                failures++;
                $display("FAIL repeat_time_%0d: strobe at n+%0d, expected n+%0d", i,
                         (i < strobes.size()) ? strobes[i] : -1, exp_k[i]);
            end
        end
        checks++;
        if (oct_sel !== 2'd3) begin
            failures++;
            $display("FAIL repeat_final: sel=%0d, expected 3", oct_sel);
        end
        do_reset();
        oct_up = 1'b1;
        for (int k = 0; k < 12; k++) step();
        oct_up = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (oct_strobe === 1'b1 || oct_pending === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0 || oct_sel !== 2'd2) begin
            failures++;
            $display("FAIL repeat_release: sel=%0d active_cycles=%0d, expected sel=2 active_cycles=0", oct_sel, cnt);
        end
    endtask

    task automatic test_reset_hold();
        int bad;
        do_reset();
        oct_up = 1'b1;
        rst    = 1'b1;
        step();
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (oct_pending !== 1'b0 || oct_strobe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || oct_sel !== 2'(DEF_OCT)) begin
            failures++;
            $display("FAIL held_through_reset: sel=%0d bad_cycles=%0d, expected sel=%0d bad_cycles=0",
                     oct_sel, bad, DEF_OCT);
        end
        oct_up = 1'b0;
        step();
        tap(1'b1);
        note_busy = 1'b1;
        oct_down  = 1'b1;
        step();
        checks++;
        if (oct_pending !== 1'b1 || oct_sel !== 2'd1) begin
            failures++;
            $display("FAIL pend_dn_setup: pending=%b sel=%0d, expected pending=1 sel=1", oct_pending, oct_sel);
        end
        rst = 1'b1;
        step();
        checks++;
        if (oct_pending !== 1'b0 || oct_sel !== 2'(DEF_OCT) || oct_strobe !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_request: pending=%b sel=%0d strobe=%b, expected pending=0 sel=%0d strobe=0",
                     oct_pending, oct_sel, oct_strobe, DEF_OCT);
        end
        rst       = 1'b0;
        oct_down  = 1'b0;
        note_busy = 1'b0;
        step();
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) oct_up = ~oct_up;
            if ($urandom_range(0, 13) == 0) oct_down = ~oct_down;
            if ($urandom_range(0, 9) == 0) note_busy = ~note_busy;
            rst = ($urandom_range(0, 399) == 0);
            step();
            checks++;
            if (oct_sel !== m_oct[1:0] || oct_strobe !== m_strobe || oct_pending !== (m_pend != 0)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle_%0d: sel=%0d strobe=%b pending=%b, expected sel=%0d strobe=%b pending=%b",
                             i, oct_sel, oct_strobe, oct_pending, m_oct, m_strobe, (m_pend != 0));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        oct_up    = 1'b0;
        oct_down  = 1'b0;
        note_busy = 1'b0;
        test_reset();
        test_single_up();
        test_saturate();
        test_busy_hold();
        test_cancel();
        test_repeat();
        test_reset_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
